// File: rtl/npc_rf_pkg.sv
// Shared constants for the GPR write-back scheduler.
//  - Default GPR index and data widths, and the register count NREG they imply.
//  - REG_X0: index of the hard-wired zero register.
//  - rr_ptr_e: which requester wins when EXU and LSU are both valid.
package npc_rf_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int NREG_DEF       = 2 ** ADDR_WIDTH_DEF;
    localparam int REG_X0         = 0;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter for the write-back port.
// The grant is combinational from valid and the priority pointer. The grant is
// also the requester's ready, so every grant completes a handshake.
// The pointer moves to the losing side only when both requesters were valid.
// Ports:
//  clk    in   rising-edge clock
//  rst    in   asynchronous active-low reset (pointer returns to RR_REQ0)
//  valid  in   [1:0] request valid, bit 0 = EXU, bit 1 = LSU
//  grant  out  [1:0] one-hot grant, zero when no request is valid
module rf_rr_arb2
    import npc_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    rr_ptr_e rr_ptr_r;
    rr_ptr_e rr_ptr_nxt_s;
    logic [1:0] grant_s;

    // Grant decode: a lone requester always wins; on contention the pointer picks.
    always_comb begin
        grant_s = 2'b00;
        case (valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = (rr_ptr_r == RR_REQ0) ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer update: after contention the loser gets priority next time.
    always_comb begin
        if (valid == 2'b11) begin
            rr_ptr_nxt_s = (rr_ptr_r == RR_REQ0) ? RR_REQ1 : RR_REQ0;
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= RR_REQ0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/rf_wb_sched.sv
// GPR write-back scheduler.
// EXU (req0) and LSU (req1) share the single RegisterFile write port through a
// round-robin arbiter. Accepted results are registered into the write stage
// (rf_wen/rf_waddr/rf_wdata). Writes to x0 complete the handshake but are dropped.
// A per-register busy scoreboard is set by IDU at issue and cleared by the write
// stage. It drives the WAW issue_ready and the RAW chk_stall.
// Optional feature macro: RF_WB_FWD_EN. When it is defined, the write in flight
// is forwarded to IDU (fwd*_hit/fwd*_data) and does not cause a stall. When it is
// undefined, the forward outputs are tied to zero.
// Ports:
//  clk, rst                  clock, asynchronous active-low reset
//  issue_valid/issue_rd      IDU issue of an instruction writing issue_rd
//  issue_ready               issue_rd is free (x0 is always free)
//  chk_rs1/chk_rs2           IDU source indices
//  chk_stall                 a source is still pending write-back
//  req0_*/req1_*             EXU / LSU results: valid, addr, data, ready
//  rf_wen/rf_waddr/rf_wdata  registered RegisterFile write port
//  fwd1_hit/fwd1_data        forward of the write in flight for rs1
//  fwd2_hit/fwd2_data        forward of the write in flight for rs2
//  busy                      scoreboard vector, bit 0 always 0
module rf_wb_sched
    import npc_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int NREG      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  chk_stall,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [DATA_WIDTH-1:0] fwd2_data,
    output logic [NREG-1:0]       busy
);

    localparam logic [ADDR_WIDTH-1:0] X0_ADDR  = ADDR_WIDTH'(REG_X0);
    localparam logic [DATA_WIDTH-1:0] ZERO_D   = {DATA_WIDTH{1'b0}};
    localparam logic [NREG-1:0]       ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [1:0]            grant_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    logic                  rf_wen_r;
    logic [ADDR_WIDTH-1:0] rf_waddr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;

    logic [NREG-1:0]       busy_r;
    logic [NREG-1:0]       busy_set_s;
    logic [NREG-1:0]       busy_clr_s;
    logic [NREG-1:0]       busy_nxt_s;

    logic                  issue_ready_s;
    logic                  fwd1_hit_s;
    logic                  fwd2_hit_s;
    logic                  stall1_s;
    logic                  stall2_s;

    rf_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Winning result mux. The write to x0 is suppressed here, so it still handshakes.
    always_comb begin
        wr_addr_s = grant_s[1] ? req1_addr : req0_addr;
        wr_data_s = grant_s[1] ? req1_data : req0_data;
        wr_en_s   = (grant_s != 2'b00) && (wr_addr_s != X0_ADDR);
    end

    // Write stage. Address and data are captured only for real writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= X0_ADDR;
            rf_wdata_r <= ZERO_D;
        end else begin
            rf_wen_r <= wr_en_s;
            if (wr_en_s) begin
                rf_waddr_r <= wr_addr_s;
                rf_wdata_r <= wr_data_s;
            end
        end
    end

    assign rf_wen   = rf_wen_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

    // WAW check: the destination must not already have a write pending.
    always_comb begin
        if (issue_rd == X0_ADDR) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = !busy_r[issue_rd];
        end
    end

    assign issue_ready = issue_ready_s;

    // Scoreboard next state. The set term is ORed after the clear, so an issue wins
    // over a write-back to the same register on the same edge. x0 is never busy.
    always_comb begin
        busy_set_s = (issue_valid && issue_ready_s && (issue_rd != X0_ADDR))
                     ? (ONE_HOT0 << issue_rd) : {NREG{1'b0}};
        busy_clr_s = (rf_wen_r && (rf_waddr_r != X0_ADDR))
                     ? (ONE_HOT0 << rf_waddr_r) : {NREG{1'b0}};
        busy_nxt_s = (busy_r & ~busy_clr_s) | busy_set_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

`ifdef RF_WB_FWD_EN
    // Forwarding: a source written this cycle is readable now, so it does not stall.
    always_comb begin
        fwd1_hit_s = rf_wen_r && (rf_waddr_r == chk_rs1);
        fwd2_hit_s = rf_wen_r && (rf_waddr_r == chk_rs2);
        stall1_s   = busy_r[chk_rs1] && !fwd1_hit_s;
        stall2_s   = busy_r[chk_rs2] && !fwd2_hit_s;
    end

    assign fwd1_data = fwd1_hit_s ? rf_wdata_r : ZERO_D;
    assign fwd2_data = fwd2_hit_s ? rf_wdata_r : ZERO_D;
`else
    // No forwarding: IDU waits until the scoreboard bit has cleared.
    always_comb begin
        fwd1_hit_s = 1'b0;
        fwd2_hit_s = 1'b0;
        stall1_s   = busy_r[chk_rs1];
        stall2_s   = busy_r[chk_rs2];
    end

    assign fwd1_data = ZERO_D;
    assign fwd2_data = ZERO_D;
`endif

    assign fwd1_hit  = fwd1_hit_s;
    assign fwd2_hit  = fwd2_hit_s;
    assign chk_stall = stall1_s || stall2_s;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched (default widths: AW=5, DW=64).
// Expectations adapt to RF_WB_FWD_EN where forwarding changes the timing.
module tb_rf_wb_sched;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic [AW-1:0] chk_rs1, chk_rs2;
    logic          chk_stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd1_data, fwd2_data;
    logic [NR-1:0] busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rf_wb_sched dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_stall(chk_stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 64'hAB;
        issue_valid = 1'b1; issue_rd = 5'd3; chk_rs1 = 5'd3;
        #2;
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL rst_req0_ready: got %0h expected 1", req0_ready); else pass_cnt++;
        tick; tick;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL rst_wen: got %0h expected 0", rf_wen); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 5'd0) $display("FAIL rst_waddr: got %0h expected 0", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 64'h0) $display("FAIL rst_wdata: got %0h expected 0", rf_wdata); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL rst_busy: got %0h expected 0", busy); else pass_cnt++;
        total_cnt++; if (chk_stall !== 1'b0) $display("FAIL rst_stall: got %0h expected 0", chk_stall); else pass_cnt++;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL rst_issue_ready: got %0h expected 1", issue_ready); else pass_cnt++;
        total_cnt++; if (fwd1_hit !== 1'b0) $display("FAIL rst_fwd1_hit: got %0h expected 0", fwd1_hit); else pass_cnt++;
        req0_valid = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h1234;
        #1;
        total_cnt++; if (req0_ready !== 1'b1) $display("FAIL single_req0_ready: got %0h expected 1", req0_ready); else pass_cnt++;
        total_cnt++; if (req1_ready !== 1'b0) $display("FAIL single_req1_ready: got %0h expected 0", req1_ready); else pass_cnt++;
        tick;
        req0_valid = 1'b0;
        total_cnt++; if (rf_wen !== 1'b1) $display("FAIL single_wen: got %0h expected 1", rf_wen); else pass_cnt++;
        total_cnt++; if (rf_waddr !== 5'd5) $display("FAIL single_waddr: got %0h expected 5", rf_waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 64'h1234) $display("FAIL single_wdata: got %0h expected 1234", rf_wdata); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL single_busy: got %0h expected 0", busy); else pass_cnt++;
        tick;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL single_wen_off: got %0h expected 0", rf_wen); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d0, d1;
        logic          exp_r0   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0] exp_addr [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [DW-1:0] exp_data [4] = '{64'hA0, 64'hB0, 64'hA1, 64'hB1};
        d0 = 64'hA0; d1 = 64'hB0;
        req0_valid = 1'b1; req0_addr = 5'd3;
        req1_valid = 1'b1; req1_addr = 5'd4;
        for (int i = 0; i < 4; i++) begin
            req0_data = d0; req1_data = d1;
            #1;
            total_cnt++; if (req0_ready !== exp_r0[i]) $display("FAIL rr_req0_ready[%0d]: got %0h expected %0h", i, req0_ready, exp_r0[i]); else pass_cnt++;
            total_cnt++; if (req1_ready !== !exp_r0[i]) $display("FAIL rr_req1_ready[%0d]: got %0h expected %0h", i, req1_ready, !exp_r0[i]); else pass_cnt++;
            tick;
            total_cnt++; if (rf_wen !== 1'b1) $display("FAIL rr_wen[%0d]: got %0h expected 1", i, rf_wen); else pass_cnt++;
            total_cnt++; if (rf_waddr !== exp_addr[i]) $display("FAIL rr_waddr[%0d]: got %0h expected %0h", i, rf_waddr, exp_addr[i]); else pass_cnt++;
            total_cnt++; if (rf_wdata !== exp_data[i]) $display("FAIL rr_wdata[%0d]: got %0h expected %0h", i, rf_wdata, exp_data[i]); else pass_cnt++;
            if (exp_r0[i]) d0 = d0 + 64'd1;
            else           d1 = d1 + 64'd1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL rr_wen_off: got %0h expected 0", rf_wen); else pass_cnt++;
    endtask

    task automatic test_raw;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL raw_issue_ready: got %0h expected 1", issue_ready); else pass_cnt++;
        tick;
        issue_valid = 1'b0; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        #1;
        total_cnt++; if (busy !== 32'h80) $display("FAIL raw_busy_set: got %0h expected 80", busy); else pass_cnt++;
        total_cnt++; if (chk_stall !== 1'b1) $display("FAIL raw_stall0: got %0h expected 1", chk_stall); else pass_cnt++;
        tick;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h77;
        #1;
        total_cnt++; if (req1_ready !== 1'b1) $display("FAIL raw_req1_ready: got %0h expected 1", req1_ready); else pass_cnt++;
        total_cnt++; if (chk_stall !== 1'b1) $display("FAIL raw_stall1: got %0h expected 1", chk_stall); else pass_cnt++;
        tick;
        req1_valid = 1'b0;
        #1;
`ifdef RF_WB_FWD_EN
        total_cnt++; if (chk_stall !== 1'b0) $display("FAIL raw_stall_wb: got %0h expected 0", chk_stall); else pass_cnt++;
        total_cnt++; if (fwd1_hit !== 1'b1) $display("FAIL raw_fwd1_hit: got %0h expected 1", fwd1_hit); else pass_cnt++;
        total_cnt++; if (fwd1_data !== 64'h77) $display("FAIL raw_fwd1_data: got %0h expected 77", fwd1_data); else pass_cnt++;
`else
        total_cnt++; if (chk_stall !== 1'b1) $display("FAIL raw_stall_wb: got %0h expected 1", chk_stall); else pass_cnt++;
        total_cnt++; if (fwd1_hit !== 1'b0) $display("FAIL raw_fwd1_hit: got %0h expected 0", fwd1_hit); else pass_cnt++;
        total_cnt++; if (fwd1_data !== 64'h0) $display("FAIL raw_fwd1_data: got %0h expected 0", fwd1_data); else pass_cnt++;
`endif
        tick;
        total_cnt++; if (chk_stall !== 1'b0) $display("FAIL raw_stall_done: got %0h expected 0", chk_stall); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL raw_busy_clr: got %0h expected 0", busy); else pass_cnt++;
        chk_rs1 = 5'd0;
    endtask

    task automatic test_waw;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL waw_first: got %0h expected 1", issue_ready); else pass_cnt++;
        tick;
        chk_rs2 = 5'd9;
        #1;
        total_cnt++; if (issue_ready !== 1'b0) $display("FAIL waw_second: got %0h expected 0", issue_ready); else pass_cnt++;
        total_cnt++; if (chk_stall !== 1'b1) $display("FAIL waw_rs2_stall: got %0h expected 1", chk_stall); else pass_cnt++;
        tick;
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h99;
        tick;
        req0_valid = 1'b0;
        #1;
        total_cnt++; if (issue_ready !== 1'b0) $display("FAIL waw_during_wb: got %0h expected 0", issue_ready); else pass_cnt++;
        tick;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL waw_after_wb: got %0h expected 1", issue_ready); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL waw_busy: got %0h expected 0", busy); else pass_cnt++;
        chk_rs2 = 5'd0; issue_rd = 5'd0;
    endtask

    task automatic test_set_wins;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 64'hC;
        tick;
        req0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd12;
        #1;
        total_cnt++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd12) $display("FAIL sw_wb: got wen=%0h addr=%0h expected wen=1 addr=c", rf_wen, rf_waddr); else pass_cnt++;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL sw_issue_ready: got %0h expected 1", issue_ready); else pass_cnt++;
        tick;
        issue_valid = 1'b0;
        total_cnt++; if (busy !== 32'h1000) $display("FAIL sw_busy: got %0h expected 1000", busy); else pass_cnt++;
        req0_valid = 1'b1; req0_data = 64'hD;
        tick;
        req0_valid = 1'b0;
        tick;
        total_cnt++; if (busy !== 32'h0) $display("FAIL sw_busy_clr: got %0h expected 0", busy); else pass_cnt++;
        issue_rd = 5'd0;
    endtask

    task automatic test_x0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'hFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        total_cnt++; if (req1_ready !== 1'b1) $display("FAIL x0_req1_ready: got %0h expected 1", req1_ready); else pass_cnt++;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL x0_issue_ready: got %0h expected 1", issue_ready); else pass_cnt++;
        tick;
        req1_valid = 1'b0; issue_valid = 1'b0;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL x0_wen: got %0h expected 0", rf_wen); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL x0_busy: got %0h expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_rst_mid;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick;
        issue_valid = 1'b0;
        total_cnt++; if (busy !== 32'h20) $display("FAIL rm_busy_set: got %0h expected 20", busy); else pass_cnt++;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h55;
        tick;
        req0_valid = 1'b0;
        total_cnt++; if (rf_wen !== 1'b1) $display("FAIL rm_wen_pending: got %0h expected 1", rf_wen); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        total_cnt++; if (busy !== 32'h0) $display("FAIL rm_busy_async: got %0h expected 0", busy); else pass_cnt++;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL rm_wen_async: got %0h expected 0", rf_wen); else pass_cnt++;
        total_cnt++; if (rf_wdata !== 64'h0) $display("FAIL rm_wdata_async: got %0h expected 0", rf_wdata); else pass_cnt++;
        tick; tick;
        rst = 1'b1;
        tick;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL rm_wen_after: got %0h expected 0", rf_wen); else pass_cnt++;
        total_cnt++; if (busy !== 32'h0) $display("FAIL rm_busy_after: got %0h expected 0", busy); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 64'h0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 64'h0;
        test_reset;
        test_single;
        test_back_to_back;
        test_raw;
        test_waw;
        test_set_wins;
        test_x0;
        test_rst_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
